// File: rtl/negexp_arbiter_if.sv
// rtl/negexp_arbiter_if.sv - requester and negexp-unit signal bundle for negexp_arbiter
// rsp_err exists only when NEGEXP_ARB_TIMEOUT_EN is defined.
interface negexp_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
`ifdef NEGEXP_ARB_TIMEOUT_EN
    logic                  rsp_err;
`endif
    logic [31:0]           ne_inp;
    logic                  ne_inp_valid;
    logic [31:0]           ne_out;
    logic                  ne_out_valid;

    modport slave (
`ifdef NEGEXP_ARB_TIMEOUT_EN
        output rsp_err,
`endif
        input  req_valid, req_data, ne_out, ne_out_valid,
        output req_ready, rsp_valid, rsp_data, ne_inp, ne_inp_valid
    );

    modport master (
`ifdef NEGEXP_ARB_TIMEOUT_EN
        input  rsp_err,
`endif
        output req_valid, req_data, ne_out, ne_out_valid,
        input  req_ready, rsp_valid, rsp_data, ne_inp, ne_inp_valid
    );
endinterface

// File: rtl/negexp_arbiter.sv
// rtl/negexp_arbiter.sv - round-robin sequencer sharing one iterative negexp unit
// Optional WAIT watchdog with rsp_err: define NEGEXP_ARB_TIMEOUT_EN.
module negexp_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FLUSH_CYCLES = 64,
    parameter int TIMEOUT      = 255,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    negexp_arbiter_if.slave     bus,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);
    localparam int FLW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || FLUSH_CYCLES < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("negexp_arbiter: parameter out of range");
    end

    state_t             state_q, state_d;
    logic [FLW-1:0]     flush_q, flush_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [31:0]        ne_inp_q, ne_inp_d;
    logic               ne_inp_valid_q, ne_inp_valid_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
`ifdef NEGEXP_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0]     wait_q, wait_d;
    logic               rsp_err_q, rsp_err_d;
`endif

    // Search upward from the slot after the last winner, wrapping.
    logic           found;
    logic [IDW-1:0] win;
    int             idx;
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(rr_q) + off) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_d        = flush_q;
        rr_d           = rr_q;
        grant_d        = grant_q;
        ne_inp_d       = ne_inp_q;
        ne_inp_valid_d = 1'b0;
        req_ready_d    = '0;
        rsp_valid_d    = '0;
        rsp_data_d     = rsp_data_q;
`ifdef NEGEXP_ARB_TIMEOUT_EN
        wait_d         = wait_q;
        rsp_err_d      = rsp_err_q;
`endif
        case (state_q)
            S_FLUSH: begin
                if (flush_q == '0) state_d = S_IDLE;
                else               flush_d = flush_q - 1'b1;
            end
            S_IDLE: begin
                if (found) begin
                    ne_inp_d         = bus.req_data[int'(win)*32 +: 32];
                    grant_d          = win;
                    rr_d             = win;
                    req_ready_d[win] = 1'b1;
                    ne_inp_valid_d   = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef NEGEXP_ARB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_WAIT: begin
                if (bus.ne_out_valid) begin
                    rsp_data_d           = bus.ne_out;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = S_RESP;
`ifdef NEGEXP_ARB_TIMEOUT_EN
                    rsp_err_d            = 1'b0;
                end else if (wait_q == TOW'(TIMEOUT)) begin
                    rsp_data_d           = 32'h7fc00000;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = S_RESP;
                end else begin
                    wait_d               = wait_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef NEGEXP_ARB_TIMEOUT_EN
                // A timed-out unit may still be iterating; drain it before reuse.
                if (rsp_err_q) begin
                    state_d = S_FLUSH;
                    flush_d = FLW'(FLUSH_CYCLES - 1);
                end
`endif
            end
            default: begin
                state_d = S_FLUSH;
                flush_d = FLW'(FLUSH_CYCLES - 1);
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FLUSH;
            flush_q        <= FLW'(FLUSH_CYCLES - 1);
            rr_q           <= IDW'(NUM_REQ - 1);
            grant_q        <= '0;
            ne_inp_q       <= '0;
            ne_inp_valid_q <= 1'b0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            busy_q         <= 1'b1;
`ifdef NEGEXP_ARB_TIMEOUT_EN
            wait_q         <= '0;
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            flush_q        <= flush_d;
            rr_q           <= rr_d;
            grant_q        <= grant_d;
            ne_inp_q       <= ne_inp_d;
            ne_inp_valid_q <= ne_inp_valid_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            busy_q         <= busy_d;
`ifdef NEGEXP_ARB_TIMEOUT_EN
            wait_q         <= wait_d;
            rsp_err_q      <= rsp_err_d;
`endif
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.ne_inp       = ne_inp_q;
    assign bus.ne_inp_valid = ne_inp_valid_q;
`ifdef NEGEXP_ARB_TIMEOUT_EN
    assign bus.rsp_err      = rsp_err_q;
`endif
    assign busy             = busy_q;
    assign grant_id         = grant_q;
endmodule

// File: tb/tb_negexp_arbiter.sv
// tb/tb_negexp_arbiter.sv - directed self-checking bench for negexp_arbiter
module tb_negexp_arbiter;
    localparam int NREQ  = 4;
    localparam int FLUSH = 16;
    localparam int LAT   = 12;
    localparam logic [31:0] KEY = 32'ha5a55a5a;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] grant_id;

    negexp_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    negexp_arbiter #(
        .NUM_REQ     (NREQ),
        .FLUSH_CYCLES(FLUSH),
        .TIMEOUT     (20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int onehot_bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk)
        if ($countones(bus.req_ready) > 1 || $countones(bus.rsp_valid) > 1) onehot_bad++;

    // negexp stand-in: result = operand ^ KEY, strobed LAT cycles after the ISSUE cycle
    logic        model_en = 1'b1;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        st;
    logic [31:0] op;

    assign bus.ne_out_valid = m_valid | i_valid;
    assign bus.ne_out       = m_valid ? m_data : i_data;

    always @(posedge clk) begin
        st = bus.ne_inp_valid;
        op = bus.ne_inp;
        #1;
        m_valid = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end
        if (st && model_en && m_cnt == 0 && !m_valid) begin
            m_cnt  = LAT - 1;
            m_data = op ^ KEY;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n, t0, prev, seen;
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_ne_inp", bus.ne_inp, 0);
        chk("rst_ne_inp_valid", 32'(bus.ne_inp_valid), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_flush_len", 32'(n), FLUSH);

        // single request from requester 2
        bus.req_data[95:64] = 32'h3f800000;
        bus.req_valid = 4'b0100;
        t0 = cyc;
        wait_ready(n);
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        chk("single_ready_cyc", 32'(cyc - t0), 1);
        chk("single_ne_inp", bus.ne_inp, 32'h3f800000);
        chk("single_inp_valid", 32'(bus.ne_inp_valid), 1);
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_inp_pulse", 32'(bus.ne_inp_valid), 0);
        wait_rsp(n);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("single_rsp_cyc", 32'(cyc - t0), 14);
        chk("single_rsp_data", bus.rsp_data, 32'h9a255a5a);
`ifdef NEGEXP_ARB_TIMEOUT_EN
        chk("single_rsp_err", 32'(bus.rsp_err), 0);
`endif
        @(negedge clk);
        chk("single_idle", 32'(busy), 0);

        // all four requesters continuously pending
        do_reset();
        bus.req_data = {32'h40400000, 32'h40000000, 32'h3f800000, 32'h3f000000};
        bus.req_valid = 4'hf;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready(n);
            chk($sformatf("rr_ready%0d", g), 32'(bus.req_ready), 32'(1 << exp_ord[g]));
            chk($sformatf("rr_grant%0d", g), 32'(grant_id), 32'(exp_ord[g]));
            if (g > 0) chk($sformatf("rr_period%0d", g), 32'(cyc - prev), LAT + 3);
            prev = cyc;
            if (g == 4) bus.req_valid = '0;
            @(negedge clk);
        end
        wait_rsp(n);
        chk("rr_last_rsp", 32'(bus.rsp_valid), 32'h1);
        chk("rr_last_data", bus.rsp_data, 32'h9aa55a5a);
        chk("rr_onehot", 32'(onehot_bad), 0);
        @(negedge clk);

        // spurious strobes in IDLE and ISSUE
        model_en = 1'b0;
        i_data = 32'hdeadbeef;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            seen |= int'(|bus.rsp_valid);
            @(negedge clk);
        end
        chk("spur_idle_rsp", 32'(seen), 0);
        chk("spur_idle_data", bus.rsp_data, 32'h9aa55a5a);
        bus.req_data[31:0] = 32'h3f800000;
        bus.req_valid = 4'b0001;
        wait_ready(n);
        bus.req_valid = '0;
        i_data = 32'hcafef00d;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk("spur_issue_rsp", 32'(bus.rsp_valid), 0);
        chk("spur_issue_busy", 32'(busy), 1);
        @(negedge clk);
        i_data = 32'h3e000000;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk("spur_wait_rsp", 32'(bus.rsp_valid), 32'h1);
        chk("spur_wait_data", bus.rsp_data, 32'h3e000000);
        @(negedge clk);

        // reset mid-WAIT with a stale strobe during FLUSH
        bus.req_data[63:32] = 32'h40a00000;
        bus.req_valid = 4'b0010;
        wait_ready(n);
        chk("mid_ready", 32'(bus.req_ready), 32'h2);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 1);
        chk("mid_rst_grant", 32'(grant_id), 0);
        chk("mid_rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        @(negedge clk);
        bus.req_data[127:96] = 32'h41000000;
        bus.req_valid = 4'b1000;
        model_en = 1'b1;
        rst_n = 1'b1;
        n = 0;
        seen = 0;
        i_data = 32'h12345678;
        while (busy && n < 100) begin
            seen |= int'(|bus.rsp_valid);
            if (n == 5) i_valid = 1'b1;
            if (n == 6) i_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        i_valid = 1'b0;
        chk("mid_flush_len", 32'(n), FLUSH);
        chk("mid_no_rsp", 32'(seen), 0);
        chk("mid_data_kept", bus.rsp_data, 0);
        @(negedge clk);
        chk("mid_first_grant", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        wait_rsp(n);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h8);
        chk("mid_rsp_data", bus.rsp_data, 32'he4a55a5a);
        @(negedge clk);

        // requester 1 drops while requester 3 raises
        bus.req_data[31:0] = 32'h3f800000;
        bus.req_valid = 4'b0001;
        wait_ready(n);
        bus.req_valid = 4'b0010;
        wait_rsp(n);
        chk("swap_rsp0", 32'(bus.rsp_valid), 32'h1);
        bus.req_data[127:96] = 32'h40000000;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("swap_ready", 32'(bus.req_ready), 32'h8);
        chk("swap_grant", 32'(grant_id), 3);
        bus.req_valid = '0;
        wait_rsp(n);
        chk("swap_rsp3", 32'(bus.rsp_valid), 32'h8);
        @(negedge clk);

`ifdef NEGEXP_ARB_TIMEOUT_EN
        model_en = 1'b0;
        bus.req_valid = 4'b0100;
        wait_ready(n);
        bus.req_valid = '0;
        @(negedge clk);
        n = 0;
        while (bus.rsp_valid == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", 32'(n), 21);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("to_rsp_err", 32'(bus.rsp_err), 1);
        chk("to_rsp_data", bus.rsp_data, 32'h7fc00000);
        @(negedge clk);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_flush_len", 32'(n), FLUSH);
        model_en = 1'b1;
`endif

        chk("onehot_total", 32'(onehot_bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/negexp_arbiter.md
# negexp_arbiter

Round-robin arbiter and sequencer that shares one `negexp` unit (single-precision e^-x approximation, iterative, non-pipelined) between NUM_REQ annealing requesters. It accepts one request at a time, issues a single-cycle `inp_valid` pulse to the unit, waits for `out_valid`, and returns the result to the granted requester. The unit has no effective reset and ignores new inputs while busy, so this block also drains the unit after reset. It sits between the per-swap acceptance logic and the shared `negexp` instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- FLUSH_CYCLES, 64: post-reset/post-timeout drain length in cycles; must exceed the `negexp` worst-case latency.
- TIMEOUT, 255: WAIT watchdog limit in cycles (used only with the macro).

- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_data  in  32*NUM_REQ  float operand, requester i at bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot result pulse.
- rsp_data  out  32  result of the last completed request.
- rsp_err  out  1  timeout flag, qualified by rsp_valid (macro only).
- ne_inp  out  32  operand to `negexp`.
- ne_inp_valid  out  1  start pulse to `negexp`.
- ne_out  in  32  `negexp` result.
- ne_out_valid  in  1  `negexp` result strobe.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last grant.

## Operation
- States: FLUSH, IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset state:
  - FLUSH with flush counter = FLUSH_CYCLES-1.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, ne_inp, ne_inp_valid, grant_id.
  - busy = 1.
- FLUSH:
  - Decrement the counter each cycle and discard ne_out_valid.
  - At 0, go to IDLE.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Latch its req_data into ne_inp, set grant_id and rr_ptr to the winner, pulse req_ready[winner] next cycle, go to ISSUE.
  - Requesters must hold req_valid and req_data until req_ready.
- ISSUE:
  - ne_inp_valid = 1 for exactly this one cycle.
  - Go to WAIT.
- WAIT:
  - On ne_out_valid, capture ne_out into rsp_data and go to RESP.
- RESP:
  - rsp_valid[grant_id] = 1 for one cycle, then go to IDLE.
  - rsp_data holds its value until the next capture.
- ne_out_valid outside WAIT is ignored in every state.
- A requester deasserting req_valid before acceptance drops out of the next arbitration; no error.
- A requester may re-request immediately after its rsp_valid. It still loses to any other pending requester, because rr_ptr has advanced past it.
- rst_n asserted in any state forces the reset state immediately. The in-flight request is lost and gets no rsp_valid. Any late `negexp` output is absorbed by FLUSH.

## Timing
- Cycle 0: IDLE samples req_valid.
- Cycle 1: req_ready pulse; state = ISSUE; ne_inp_valid high.
- Cycle 2: WAIT begins; `negexp` sees the start at this edge.
- If ne_out_valid is first high at cycle k, rsp_valid is high at cycle k+1 and the state is IDLE at k+2.
- Arbitration overhead: 3 cycles beyond the `negexp` latency, so throughput is one request per (L+3) cycles.
- First acceptance after reset release: no earlier than cycle FLUSH_CYCLES.

## Configuration
- `NEGEXP_ARB_TIMEOUT_EN` defined:
  - A WAIT cycle counter is added and the rsp_err port exists.
  - If TIMEOUT cycles elapse in WAIT without ne_out_valid, go to RESP with rsp_data = 32'h7fc00000 (qNaN) and rsp_err = 1.
  - After that RESP, go to FLUSH instead of IDLE.
  - rsp_err = 0 on normal responses.
- Undefined:
  - No counter and no rsp_err port.
  - WAIT holds indefinitely.

## Test plan
- Single request, requester 2 with 32'h3f800000 (1.0), model latency 12: req_ready at cycle 1, ne_inp = 32'h3f800000 with one ne_inp_valid pulse, rsp_valid[2] at issue+13, rsp_data = model output.
- All 4 requesters hold req_valid continuously: grant order 0,1,2,3,0, each served once per (L+3) cycles, never two one-hot bits set.
- Spurious ne_out_valid injected during IDLE and ISSUE: no rsp_valid and rsp_data unchanged; only the WAIT-phase strobe produces a response.
- rst_n pulsed low mid-WAIT, then the model's stale out_valid arrives 5 cycles after release: busy = 1 for FLUSH_CYCLES cycles, no rsp_valid, first new grant after FLUSH.
- With `NEGEXP_ARB_TIMEOUT_EN` and TIMEOUT = 20, model never responds: rsp_valid[grant] with rsp_err = 1 and rsp_data = 32'h7fc00000 at WAIT entry+21, then FLUSH.
- Requester 1 drops req_valid in the same cycle requester 3 raises it while IDLE: requester 3 is granted and requester 1 gets no req_ready.
